// File: rtl/timer_pkg.sv
// Shared constants for the programmable timer: register selects, CTRL bit positions
// and the channel-index width helper.
package timer_pkg;

   localparam logic [1:0] REG_LOAD       = 2'd0;
   localparam logic [1:0] REG_CTRL       = 2'd1;
   localparam logic [1:0] REG_PRESCALE   = 2'd2;
   localparam logic [1:0] REG_STATUS_CLR = 2'd3;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQ_EN   = 2;

   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: LOAD/CTRL registers, the down-counter, and the pulse and sticky status.
// Expiry fires on a tick while the count is 1. Periodic channels then reload from LOAD.
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_tick,
   input  logic             i_load_we,
   input  logic             i_ctrl_we,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count,
   output logic             o_pulse,
   output logic             o_status,
   output logic             o_irq_req
);

   logic [WIDTH-1:0] r_load;
   logic [WIDTH-1:0] r_count;
   logic             r_enable;
   logic             r_periodic;
   logic             r_irq_en;
   logic             r_pulse;
   logic             r_status;
   logic             w_expire;

   assign w_expire = !i_ctrl_we && r_enable && i_tick && (r_count <= WIDTH'(1));

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_load     <= '0;
         r_count    <= '0;
         r_enable   <= 1'b0;
         r_periodic <= 1'b0;
         r_irq_en   <= 1'b0;
         r_pulse    <= 1'b0;
         r_status   <= 1'b0;
      end else begin
         r_pulse <= w_expire;
         if (i_load_we) r_load <= i_data;
         if (i_ctrl_we) begin
            r_irq_en   <= i_data[CTRL_IRQ_EN];
            r_periodic <= i_data[CTRL_PERIODIC];
            // A zero LOAD can never expire, so the channel refuses to start.
            if (i_data[CTRL_ENABLE] && (r_load != '0)) begin
               r_enable <= 1'b1;
               r_count  <= r_load;
            end else begin
               r_enable <= 1'b0;
            end
         end else if (r_enable && i_tick) begin
            if (!w_expire) begin
               r_count <= r_count - WIDTH'(1);
            end else if (r_periodic) begin
               r_count <= r_load;
            end else begin
               r_count  <= '0;
               r_enable <= 1'b0;
            end
         end
         // Same-cycle expiry wins over a clear so no event is lost.
         if (w_expire)   r_status <= 1'b1;
         else if (i_clr) r_status <= 1'b0;
      end
   end

   assign o_count   = r_count;
   assign o_pulse   = r_pulse;
   assign o_status  = r_status;
   assign o_irq_req = r_status & r_irq_en;

endmodule

// File: rtl/programmable_timer.sv
// Multi-channel programmable timer: write decode, shared prescaler, read mux and irq reduction.
// Define TIMER_PRESCALER_EN to include the PRESCALE register; otherwise every clock is a tick.
module programmable_timer
   import timer_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int WIDTH          = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_wr_en,
   input  logic [chan_w(CHANNELS)-1:0]   i_wr_channel,
   input  logic [1:0]                    i_wr_reg,
   input  logic [WIDTH-1:0]              i_wr_data,
   input  logic [chan_w(CHANNELS)-1:0]   i_rd_channel,
   output logic [WIDTH-1:0]              o_rd_count,
   output logic [CHANNELS-1:0]           o_pulse,
   output logic [CHANNELS-1:0]           o_status,
   output logic                          o_irq
);

   localparam int CW = chan_w(CHANNELS);

   logic                            w_tick;
   logic [CHANNELS-1:0][WIDTH-1:0]  w_count;
   logic [CHANNELS-1:0]             w_irq_req;
   logic [WIDTH-1:0]                w_rd_count;

`ifdef TIMER_PRESCALER_EN
   logic [PRESCALE_WIDTH-1:0] r_presc;
   logic [PRESCALE_WIDTH-1:0] r_pcnt;

   assign w_tick = (r_pcnt == r_presc);

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_presc <= '0;
         r_pcnt  <= '0;
      end else if (i_wr_en && (i_wr_reg == REG_PRESCALE)) begin
         r_presc <= i_wr_data[PRESCALE_WIDTH-1:0];
         r_pcnt  <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end
`else
   // Prescaler counter and setting both tied to zero, so the tick compare is always true.
   logic [PRESCALE_WIDTH-1:0] w_pcnt;
   assign w_pcnt = '0;
   assign w_tick = (w_pcnt == '0);
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic w_load_we;
      logic w_ctrl_we;
      logic w_clr;

      assign w_load_we = i_wr_en && (i_wr_reg == REG_LOAD) && (i_wr_channel == CW'(g));
      assign w_ctrl_we = i_wr_en && (i_wr_reg == REG_CTRL) && (i_wr_channel == CW'(g));
      if (g < WIDTH) begin : g_clr
         assign w_clr = i_wr_en && (i_wr_reg == REG_STATUS_CLR) && i_wr_data[g];
      end else begin : g_noclr
         assign w_clr = 1'b0;
      end

      timer_channel #(.WIDTH(WIDTH)) u_channel (
         .i_clock   (i_clock),
         .i_reset   (i_reset),
         .i_tick    (w_tick),
         .i_load_we (w_load_we),
         .i_ctrl_we (w_ctrl_we),
         .i_data    (i_wr_data),
         .i_clr     (w_clr),
         .o_count   (w_count[g]),
         .o_pulse   (o_pulse[g]),
         .o_status  (o_status[g]),
         .o_irq_req (w_irq_req[g])
      );
   end

   always_comb begin
      w_rd_count = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (i_rd_channel == CW'(i)) w_rd_count = w_count[i];
      end
   end

   assign o_rd_count = w_rd_count;
   assign o_irq      = |w_irq_req;

endmodule

// File: tb/tb_programmable_timer.sv
// Directed bench for programmable_timer with hand-computed expectations and immediate assertions.
module tb_programmable_timer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [1:0]  wr_channel;
   logic [1:0]  wr_reg;
   logic [15:0] wr_data;
   logic [1:0]  rd_channel;
   logic [15:0] rd_count;
   logic [3:0]  pulse;
   logic [3:0]  status;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

`ifdef TIMER_PRESCALER_EN
   localparam int EXP_PERIOD = 16;
`else
   localparam int EXP_PERIOD = 4;
`endif

   programmable_timer #(.CHANNELS(4), .WIDTH(16), .PRESCALE_WIDTH(8)) dut (
      .i_clock      (clk),
      .i_reset      (rst_n),
      .i_wr_en      (wr_en),
      .i_wr_channel (wr_channel),
      .i_wr_reg     (wr_reg),
      .i_wr_data    (wr_data),
      .i_rd_channel (rd_channel),
      .o_rd_count   (rd_count),
      .o_pulse      (pulse),
      .o_status     (status),
      .o_irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] ch, input logic [1:0] rg, input logic [15:0] d);
      wr_en = 1'b1; wr_channel = ch; wr_reg = rg; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] ch, input logic [15:0] exp);
      rd_channel = ch;
      #1;
      chk(tag, {16'h0, rd_count}, {16'h0, exp});
   endtask

   initial begin
      int cnt;
      bit found;

      // reset held with random writes in flight
      rst_n = 1'b0; wr_en = 1'b1; rd_channel = 2'd0;
      wr_channel = 2'($urandom_range(0, 3)); wr_reg = 2'($urandom_range(0, 3));
      wr_data = 16'($urandom);
      step();
      wr_channel = 2'($urandom_range(0, 3)); wr_reg = 2'd1; wr_data = 16'hFFFF;
      step();
      chk("rst_pulse", {28'h0, pulse}, 32'h0);
      chk("rst_status", {28'h0, status}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      wr_en = 1'b0; rst_n = 1'b1;
      step();
      for (int c = 0; c < 4; c++) rd_chk("rst_count", 2'(c), 16'd0);

      // one-shot, channel 0, LOAD 5
      wr(2'd0, 2'd0, 16'd5);
      wr(2'd0, 2'd1, 16'b001);
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("os_pulse", {31'h0, pulse[0]}, {31'h0, (k == 5)});
         if (k == 5) begin
            chk("os_status", {31'h0, status[0]}, 32'h1);
            chk("os_irq", {31'h0, irq}, 32'h0);
         end
      end
      rd_chk("os_count", 2'd0, 16'd0);
      step(); step(); step();
      chk("os_nopulse", {28'h0, pulse}, 32'h0);
      rd_chk("os_count_hold", 2'd0, 16'd0);
      wr(2'd3, 2'd3, 16'h0001);
      chk("os_clr", {28'h0, status}, 32'h0);

      // periodic with irq, channel 2, LOAD 3
      wr(2'd2, 2'd0, 16'd3);
      wr(2'd2, 2'd1, 16'b111);
      for (int k = 1; k <= 30; k++) begin
         step();
         chk("per_pulse", {31'h0, pulse[2]}, {31'h0, (k % 3 == 0)});
         chk("per_irq", {31'h0, irq}, {31'h0, (k >= 3)});
      end
      step(); step();
      wr(2'd0, 2'd3, 16'h0004);
      chk("clr_coll_pulse", {31'h0, pulse[2]}, 32'h1);
      chk("clr_coll_status", {31'h0, status[2]}, 32'h1);
      wr(2'd0, 2'd3, 16'h0004);
      chk("clr_status", {28'h0, status}, 32'h0);
      chk("clr_irq", {31'h0, irq}, 32'h0);
      wr(2'd2, 2'd1, 16'b000);
      step(); step(); step();
      chk("dis_pulse", {28'h0, pulse}, 32'h0);
      rd_chk("dis_freeze", 2'd2, 16'd2);

      // prescaler: channel 1, LOAD 4 periodic, PRESCALE 3
      wr(2'd0, 2'd2, 16'd3);
      wr(2'd1, 2'd0, 16'd4);
      wr(2'd1, 2'd1, 16'b011);
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         step();
         if (pulse[1]) found = 1'b1;
      end
      chk("psc_first", {31'h0, found}, 32'h1);
      for (int p = 0; p < 2; p++) begin
         cnt = 0;
         do begin
            step();
            cnt++;
         end while (!pulse[1] && cnt < 200);
         chk("psc_period", cnt, EXP_PERIOD);
      end
      wr(2'd1, 2'd1, 16'b000);
      wr(2'd0, 2'd2, 16'd0);
      wr(2'd0, 2'd3, 16'h000F);
      chk("psc_clr", {28'h0, status}, 32'h0);

      // LOAD = 0 with enable never pulses
      wr(2'd3, 2'd1, 16'b001);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (pulse[3]) cnt++;
      end
      chk("load0_pulses", cnt, 0);
      chk("load0_status", {31'h0, status[3]}, 32'h0);
      rd_chk("load0_count", 2'd3, 16'd0);

      // LOAD rewritten mid-count: pulse after 2, then every 7
      wr(2'd0, 2'd0, 16'd2);
      wr(2'd0, 2'd1, 16'b011);
      wr(2'd0, 2'd0, 16'd7);
      chk("rl_pre", {31'h0, pulse[0]}, 32'h0);
      step();
      chk("rl_first", {31'h0, pulse[0]}, 32'h1);
      for (int k = 1; k <= 14; k++) begin
         step();
         chk("rl_pulse", {31'h0, pulse[0]}, {31'h0, (k == 7 || k == 14)});
      end
      wr(2'd0, 2'd1, 16'b000);
      wr(2'd0, 2'd3, 16'h000F);

      // reset while count = 1 abandons the expiry
      wr(2'd1, 2'd0, 16'd3);
      wr(2'd1, 2'd1, 16'b001);
      step(); step();
      rd_chk("rc_count1", 2'd1, 16'd1);
      rst_n = 1'b0;
      step();
      chk("rc_pulse", {28'h0, pulse}, 32'h0);
      chk("rc_status", {28'h0, status}, 32'h0);
      chk("rc_irq", {31'h0, irq}, 32'h0);
      rd_chk("rc_count", 2'd1, 16'd0);
      rst_n = 1'b1;
      step();
      chk("rc_post_pulse", {28'h0, pulse}, 32'h0);
      step();
      chk("rc_post_status", {28'h0, status}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
